param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ram_2p.sv | 41 ++++
 rtl/param_sync_fifo.sv | 107 ++++++++++
 tb/tb_param_sync_fifo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
// Holds default geometry and the pointer-width to depth mapping.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  // Number of storage entries addressed by an addr_w-bit index.
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ram_2p.sv
// Two-port storage: one write port, one registered read port.
// The array is never cleared; only the read register has a reset value.
module fifo_ram_2p
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage arrays get no reset branch; clearing them would force
  // flops instead of RAM, and stale entries are never observable anyway.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: non-blocking assignment here means the read samples the array
  // before this edge's write, so a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : fifo_ram_2p

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with wrap-bit pointers, registered
// status flags, occupancy count and rejected-request pulses.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int AF_LVL = fifo_depth(ADDR_W) - 2,
  parameter int AE_LVL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("param_sync_fifo: DATA_W must be >= 1");
  end
  if (ADDR_W < 2) begin : g_bad_addr_w
    $error("param_sync_fifo: ADDR_W must be >= 2");
  end
  if (!(AE_LVL < AF_LVL && AF_LVL <= DEPTH)) begin : g_bad_levels
    $error("param_sync_fifo: need AE_LVL < AF_LVL <= DEPTH");
  end

  localparam logic [ADDR_W:0] AF_CNT = AF_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_CNT = AE_LVL[ADDR_W:0];

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] wr_ptr_nxt;
  logic [ADDR_W:0] rd_ptr_nxt;
  logic [ADDR_W:0] count_nxt;
  logic            wr_acc;
  logic            rd_acc;
  logic            full_nxt;
  logic            empty_nxt;

  // No bypass: a read needs a stored word, while a write into a full FIFO
  // is allowed when a read frees a slot on the same edge.
  assign rd_acc     = rd_en && !empty;
  assign wr_acc     = wr_en && (!full || rd_acc);

  assign wr_ptr_nxt = wr_ptr + {{ADDR_W{1'b0}}, wr_acc};
  assign rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, rd_acc};
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  assign full_nxt   = (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]) &&
                      (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]);
  assign empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);

  // Flags are registered from the next-state pointers, so every flag agrees
  // with count in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (AF_CNT == '0);
      almost_empty <= 1'b1;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= full_nxt;
      empty        <= empty_nxt;
      almost_full  <= (count_nxt >= AF_CNT);
      almost_empty <= (count_nxt <= AE_CNT);
      rd_valid     <= rd_acc;
      overflow     <= wr_en && !wr_acc;
      underflow    <= rd_en && !rd_acc;
    end
  end

  fifo_ram_2p #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

endmodule : param_sync_fifo

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: directed scenarios plus random
// traffic, all compared every cycle against a queue-based reference model.
module tb_param_sync_fifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AF_LVL = 14;
  localparam int AE_LVL = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_rd_data;
  logic              m_rd_valid;
  logic              m_overflow;
  logic              m_underflow;

  always #5 clk = ~clk;

  param_sync_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .AF_LVL (AF_LVL),
    .AE_LVL (AE_LVL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update from the rules: read needs a stored word, write needs room
  // or a simultaneous accepted read; reset wins over everything.
  task automatic model_edge(input logic we, input logic [DATA_W-1:0] wd,
                            input logic re, input logic rs);
    bit rd_ok, wr_ok;
    if (rs) begin
      q.delete();
      m_rd_data   = '0;
      m_rd_valid  = 1'b0;
      m_overflow  = 1'b0;
      m_underflow = 1'b0;
    end else begin
      rd_ok = re && (q.size() > 0);
      wr_ok = we && ((q.size() < DEPTH) || rd_ok);
      m_rd_valid  = rd_ok;
      m_overflow  = we && !wr_ok;
      m_underflow = re && !rd_ok;
      if (rd_ok) m_rd_data = q.pop_front();
      if (wr_ok) q.push_back(wd);
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    check("count",        32'(count),        32'(n));
    check("full",         32'(full),         32'(n == DEPTH));
    check("empty",        32'(empty),        32'(n == 0));
    check("almost_full",  32'(almost_full),  32'(n >= AF_LVL));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE_LVL));
    check("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
    check("rd_data",      32'(rd_data),      32'(m_rd_data));
    check("overflow",     32'(overflow),     32'(m_overflow));
    check("underflow",    32'(underflow),    32'(m_underflow));
  endtask

  // One clock: drive inputs, update model at the edge, compare 1ns later.
  task automatic step(input logic we, input logic [DATA_W-1:0] wd,
                      input logic re, input logic rs);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    reset   = rs;
    @(posedge clk);
    model_edge(we, wd, re, rs);
    #1;
    compare_all();
  endtask

  initial begin
    int wp, rp;
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; reset = 1'b1;
    m_rd_data = '0; m_rd_valid = 1'b0; m_overflow = 1'b0; m_underflow = 1'b0;
    #2;

    // Reset then idle
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("lit_reset_empty",  32'(empty),        32'd1);
    check("lit_reset_ae",     32'(almost_empty), 32'd1);
    check("lit_reset_count",  32'(count),        32'd0);
    check("lit_reset_full",   32'(full),         32'd0);
    check("lit_reset_rdv",    32'(rd_valid),     32'd0);
    check("lit_reset_rddata", 32'(rd_data),      32'h00);

    // Fill 0x00..0x0F, then one overflowing write
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 12) check("lit_af_before_14", 32'(almost_full), 32'd0);
      if (i == 13) check("lit_af_at_14",     32'(almost_full), 32'd1);
    end
    check("lit_full_16",  32'(full),  32'd1);
    check("lit_count_16", 32'(count), 32'd16);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check("lit_overflow_17", 32'(overflow), 32'd1);
    check("lit_count_17",    32'(count),    32'd16);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("lit_overflow_clear", 32'(overflow), 32'd0);

    // Drain in order, then one underflowing read
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("lit_drain_data",  32'(rd_data),  32'(i));
      check("lit_drain_valid", 32'(rd_valid), 32'd1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("lit_underflow_17", 32'(underflow), 32'd1);
    check("lit_rdv_17",       32'(rd_valid),  32'd0);
    check("lit_empty_17",     32'(empty),     32'd1);

    // Full FIFO with simultaneous read and write for 20 cycles
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'hAA, 1'b1, 1'b0);
      check("lit_rw_full_count", 32'(count),    32'd16);
      check("lit_rw_full_ovf",   32'(overflow), 32'd0);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("lit_last_aa", 32'(rd_data), 32'hAA);

    // Empty FIFO with simultaneous read and write
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("lit_rw_empty_unf",   32'(underflow), 32'd1);
    check("lit_rw_empty_count", 32'(count),     32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("lit_rw_empty_data",  32'(rd_data),   32'h55);

    // Reset with requests pending
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b1);
    check("lit_rst_count", 32'(count),     32'd0);
    check("lit_rst_empty", 32'(empty),     32'd1);
    check("lit_rst_ovf",   32'(overflow),  32'd0);
    check("lit_rst_unf",   32'(underflow), 32'd0);
    check("lit_rst_rdv",   32'(rd_valid),  32'd0);

    // Random traffic with phase-varying bias to visit full and empty
    for (int ph = 0; ph < 12; ph++) begin
      wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      rp = 100 - wp;
      for (int i = 0; i < 200; i++) begin
        step(1'($urandom_range(0, 99) < wp), 8'($urandom),
             1'($urandom_range(0, 99) < rp), 1'($urandom_range(0, 199) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_param_sync_fifo
